// File: rtl/neuron_mac_stage.sv
// neuron_mac_stage: multiply-accumulate neuron stage.
// Each accepted (x, w) pair adds x*w to the accumulator. The rising edge of the
// counter's ack_mac flag adds the bias. The sum is then scaled, activated and
// saturated, and the result is offered downstream.
// Optional feature macro: NEURON_RELU_EN (ReLU activation; identity when undefined).
// All state updates happen on the falling clock edge.
//
// Handshake: the output is transferred on a falling edge where out_valid=1 and
// out_ready=1. out_valid, out_data and out_sat stay stable until that edge.
// An input sample is accepted on a falling edge where ack=1 and in_ready=1.
module neuron_mac_stage #(
    parameter int DATA_W    = 8,
    parameter int WEIGHT_W  = 8,
    parameter int ACC_W     = 20,
    parameter int FRAC_BITS = 0,
    parameter int OUT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ack,
    input  logic signed [DATA_W-1:0]   x,
    input  logic signed [WEIGHT_W-1:0] w,
    input  logic                       ack_mac,
    input  logic signed [ACC_W-1:0]    bias,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       out_sat,
    output logic [1:0]                 dbg_state_o
);

    localparam int PROD_W  = DATA_W + WEIGHT_W;
    localparam int OUT_MAX = (2 ** (OUT_W - 1)) - 1;
    localparam int OUT_MIN = -(2 ** (OUT_W - 1));

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(OUT_MAX);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(OUT_MIN);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_BIAS  = 2'd1,
        ST_ACT   = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    mac_q;
    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_data_q;
    logic                    out_sat_q;

    logic                     start;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [OUT_W-1:0]  res_d;
    logic                     sat_d;

    // Only the rising edge of the level flag starts a bias/output sequence.
    assign start    = ack_mac & ~mac_q;
    assign prod     = PROD_W'(x) * PROD_W'(w);
    assign prod_ext = ACC_W'(prod);
    assign scaled   = acc_q >>> FRAC_BITS;

    assign in_ready    = (state_q == ST_ACCUM);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign dbg_state_o = state_q;

    // Activation followed by saturation to the signed output range.
    always_comb begin
        res_d = scaled[OUT_W-1:0];
        sat_d = 1'b0;
`ifdef NEURON_RELU_EN
        if (scaled[ACC_W-1]) begin
            res_d = '0;
        end else if (scaled > SAT_MAX) begin
            res_d = OUT_W'(OUT_MAX);
            sat_d = 1'b1;
        end
`else
        if (scaled > SAT_MAX) begin
            res_d = OUT_W'(OUT_MAX);
            sat_d = 1'b1;
        end else if (scaled < SAT_MIN) begin
            res_d = OUT_W'(OUT_MIN);
            sat_d = 1'b1;
        end
`endif
    end

    // Sequencer: accumulate, add bias, activate, then hold the result until it is taken.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            mac_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            // The edge detector tracks in every state, so a start seen outside ACCUM is consumed.
            mac_q <= ack_mac;
            case (state_q)
                ST_ACCUM: begin
                    if (ack) begin
                        acc_q <= acc_q + prod_ext;
                    end
                    if (start) begin
                        state_q <= ST_BIAS;
                    end
                end
                ST_BIAS: begin
                    acc_q   <= acc_q + bias;
                    state_q <= ST_ACT;
                end
                ST_ACT: begin
                    out_data_q  <= res_d;
                    out_sat_q   <= sat_d;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        state_q     <= ST_ACCUM;
                    end
                end
                default: state_q <= ST_ACCUM;
            endcase
        end
    end

endmodule
